// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words and keeps a running XOR checksum.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word,
    output logic [7:0]  o_chk
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_idx;
    logic [23:0] r_word;
    logic [7:0]  r_chk;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx <= 2'd0;
            r_chk <= 8'd0;
        end else if (i_vld) begin
            r_idx <= r_idx + 2'd1;
            r_chk <= r_chk ^ i_byte;
        end
    end

    // Only the three low bytes are stored; the top byte is taken straight from the input.
    always_ff @(posedge clk) begin
        if (i_vld) begin
            case (r_idx)
                2'd0:    r_word[7:0]   <= i_byte;
                2'd1:    r_word[15:8]  <= i_byte;
                2'd2:    r_word[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    assign o_word_vld = i_vld && (r_idx == LAST_IDX);
    assign o_word     = {i_byte, r_word};
    assign o_chk      = r_chk;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory write port; holds the core until a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH  = 64,
    parameter int         ADDR_W = $clog2(DEPTH),
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [8:0]      DEPTH_LIM = 9'(DEPTH);
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state, w_state_nxt;
    logic              w_hs, w_start, w_pack_vld, w_word_vld, w_last_word, w_n_ok;
    logic [31:0]       w_word;
    logic [7:0]        w_chk;
    logic [ADDR_W:0]   r_n, r_words;
    logic              r_we, r_hold, r_done, r_err;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    assign s_ready     = !reset;
    assign w_hs        = s_valid && s_ready;
    assign w_pack_vld  = w_hs && (r_state == DATA);
    assign w_last_word = (r_words + ONE_WORD) == r_n;
    assign w_n_ok      = (s_data != 8'd0) && ({1'b0, s_data} <= DEPTH_LIM);

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start),
        .i_vld      (w_pack_vld),
        .i_byte     (s_data),
        .o_word_vld (w_word_vld),
        .o_word     (w_word),
        .o_chk      (w_chk)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // MAGIC restarts only from the idle/terminal states; inside a frame it is ordinary data.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (w_hs && (s_data == MAGIC)) begin
                    w_state_nxt = COUNT;
                    w_start     = 1'b1;
                end
            end
            COUNT: if (w_hs) w_state_nxt = w_n_ok ? DATA : ERROR;
            DATA:  if (w_word_vld && w_last_word) w_state_nxt = CHECK;
            CHECK: if (w_hs) w_state_nxt = (s_data == w_chk) ? DONE : ERROR;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 32'd0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
            r_n     <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_hold  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_words <= '0;
            end
            if (w_hs && (r_state == COUNT)) r_n <= s_data[ADDR_W:0];
            // The word counter doubles as the write address within the frame.
            if (w_word_vld) begin
                r_we    <= 1'b1;
                r_waddr <= r_words[ADDR_W-1:0];
                r_wdata <= w_word;
                r_words <= r_words + ONE_WORD;
            end
            if ((w_state_nxt == DONE) && (r_state != DONE)) begin
                r_done <= 1'b1;
                r_hold <= 1'b0;
            end
            if ((w_state_nxt == ERROR) && (r_state != ERROR)) begin
                r_err  <= 1'b1;
                r_hold <= 1'b1;
            end
        end
    end

    assign mem_we       = r_we;
    assign mem_waddr    = r_waddr;
    assign mem_wdata    = r_wdata;
    assign cpu_hold     = r_hold;
    assign load_done    = r_done;
    assign load_err     = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, error paths, gaps and mid-frame reset.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              reset;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts write pulses; sampled before the edge's updates so each pulse is seen once.
    always @(posedge clk) if (mem_we === 1'b1) wr_cnt = wr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        idle(2);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd1);
        check("rst_done",  32'(load_done), 32'd0);
        check("rst_err",   32'(load_err), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(s_ready), 32'd1);

        // Leading junk, then a good two-word frame with a gap mid-word
        send(8'h00); send(8'hFF); send(8'h13);
        check("junk_no_write", 32'(wr_cnt), 32'd0);
        send(8'hA5); send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        check("a_we0",    32'(mem_we), 32'd1);
        check("a_addr0",  32'(mem_waddr), 32'd0);
        check("a_data0",  mem_wdata, 32'h0000_0013);
        check("a_words1", 32'(words_loaded), 32'd1);
        send(8'hB3);
        check("a_we_pulse", 32'(mem_we), 32'd0);
        send(8'h82);
        idle(3);
        check("gap_no_we", 32'(mem_we), 32'd0);
        check("gap_words", 32'(words_loaded), 32'd1);
        send(8'h41); send(8'h00);
        check("a_we1",   32'(mem_we), 32'd1);
        check("a_addr1", 32'(mem_waddr), 32'd1);
        check("a_data1", mem_wdata, 32'h0041_82B3);
        check("a_hold_before_chk", 32'(cpu_hold), 32'd1);
        send(8'h63);
        check("a_done",  32'(load_done), 32'd1);
        check("a_hold",  32'(cpu_hold), 32'd0);
        check("a_err",   32'(load_err), 32'd0);
        check("a_words", 32'(words_loaded), 32'd2);
        idle(1);
        check("a_wr_cnt", 32'(wr_cnt), 32'd2);

        // Bad checksum: writes still happen, frame rejected
        send(8'hA5);
        check("restart_hold",  32'(cpu_hold), 32'd1);
        check("restart_done",  32'(load_done), 32'd0);
        check("restart_words", 32'(words_loaded), 32'd0);
        send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'hB3); send(8'h82); send(8'h41); send(8'h00);
        send(8'h64);
        check("bad_err",   32'(load_err), 32'd1);
        check("bad_done",  32'(load_done), 32'd0);
        check("bad_hold",  32'(cpu_hold), 32'd1);
        check("bad_words", 32'(words_loaded), 32'd2);
        idle(1);
        check("bad_wr_cnt", 32'(wr_cnt), 32'd4);

        // Good frame after an error
        send(8'hA5);
        check("err_cleared", 32'(load_err), 32'd0);
        send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'hB3); send(8'h82); send(8'h41); send(8'h00);
        send(8'h63);
        check("good2_done", 32'(load_done), 32'd1);
        check("good2_err",  32'(load_err), 32'd0);
        idle(1);
        check("good2_wr_cnt", 32'(wr_cnt), 32'd6);

        // MAGIC bytes inside the payload are plain data
        send(8'hA5); send(8'h01);
        send(8'hA5); send(8'hA5); send(8'hA5); send(8'hA5);
        check("magic_data_addr", 32'(mem_waddr), 32'd0);
        check("magic_data_word", mem_wdata, 32'hA5A5_A5A5);
        send(8'h00);
        check("magic_data_done", 32'(load_done), 32'd1);
        idle(1);
        check("magic_wr_cnt", 32'(wr_cnt), 32'd7);

        // Illegal counts
        send(8'hA5); send(8'h00);
        check("n0_err",  32'(load_err), 32'd1);
        check("n0_hold", 32'(cpu_hold), 32'd1);
        check("n0_done", 32'(load_done), 32'd0);
        send(8'hA5); send(8'h41);
        check("n65_err", 32'(load_err), 32'd1);
        idle(1);
        check("nbad_wr_cnt", 32'(wr_cnt), 32'd7);
        send(8'hA5); send(8'h40);
        check("n64_accepted", 32'(load_err), 32'd0);

        // Reset mid-frame: word 1 must never be written
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send(8'hA5); send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11); send(8'h22);
        reset = 1'b1;
        idle(1);
        check("mid_rst_we",    32'(mem_we), 32'd0);
        check("mid_rst_hold",  32'(cpu_hold), 32'd1);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;
        send(8'h33); send(8'h44);
        idle(1);
        check("mid_rst_wr_cnt", 32'(wr_cnt), 32'd8);

        send(8'hA5); send(8'h01);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check("post_rst_we",   32'(mem_we), 32'd1);
        check("post_rst_addr", 32'(mem_waddr), 32'd0);
        check("post_rst_data", mem_wdata, 32'hDEAD_BEEF);
        send(8'h22);
        check("post_rst_done",  32'(load_done), 32'd1);
        check("post_rst_hold",  32'(cpu_hold), 32'd0);
        check("post_rst_words", 32'(words_loaded), 32'd1);
        send(8'hA5);
        check("rehold_hold", 32'(cpu_hold), 32'd1);
        check("rehold_done", 32'(load_done), 32'd0);
        idle(1);
        check("final_wr_cnt", 32'(wr_cnt), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that writes the writable port of the instruction memory. It replaces hard-coded initial contents with a framed download from a UART/debug byte source. It packs little-endian bytes into 32-bit instruction words, writes them to consecutive word addresses starting at 0, and checks a frame checksum. It holds the core in reset until a frame has loaded cleanly.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words (must match imem array size)
ADDR_W, $clog2(DEPTH), word-address width of the write port
MAGIC, 8'hA5, frame start byte

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
s_valid  input  1  byte-stream valid
s_data  input  8  byte-stream data
s_ready  output  1  byte accepted when s_valid && s_ready
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
mem_waddr  output  ADDR_W  word address (byte address >> 2)
mem_wdata  output  32  instruction word
cpu_hold  output  1  1 = keep core in reset
load_done  output  1  last frame loaded and checksum matched
load_err  output  1  last frame rejected
words_loaded  output  ADDR_W+1  words written in current/last frame

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high (fixed).
- Reset values: state=IDLE, s_ready=0 while reset high, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0. Checksum, byte index and word count are cleared.
- s_ready=1 in every state when reset is low. The block consumes one byte per cycle and never back-pressures.
- A handshake is s_valid && s_ready. Non-handshake cycles change nothing, so gaps are allowed anywhere, including mid-word.
- IDLE: a byte equal to MAGIC goes to COUNT and sets cpu_hold=1, load_done=0, load_err=0, words_loaded=0, chk=0. Any other byte is dropped.
- COUNT: the byte is N.
  - N==0 or N>DEPTH: go to ERROR.
  - Otherwise latch N and go to DATA with byte_idx=0, word_idx=0.
- DATA: byte k is placed in bits [8k+7:8k] and chk ^= byte.
  - On the handshake with byte_idx==3, the registered outputs update in the next cycle: mem_we=1 for exactly one cycle, mem_waddr=word_idx, mem_wdata=assembled word. Write latency is 1 cycle after the 4th byte.
  - On that same write, words_loaded increments, word_idx increments, and byte_idx wraps to 0.
  - After word N-1, go to CHECK.
- CHECK: byte==chk goes to DONE; otherwise ERROR.
- DONE: load_done=1, cpu_hold=0. A MAGIC byte restarts as in IDLE; other bytes are dropped.
- ERROR: load_err=1, cpu_hold=1, mem_we never asserted. Words already written are not rolled back. A MAGIC byte restarts; other bytes are dropped.
- A MAGIC value inside COUNT, DATA or CHECK is treated as data, not as a restart.
- word_idx never exceeds N-1 ≤ DEPTH-1, so the address never wraps.
- Reset mid-frame: all state returns to reset values next cycle. Partial word is discarded and no write is issued. A pending mem_we from the same edge is suppressed, because reset has priority.
- Both mem_we and cpu_hold are registered outputs (no combinational path from s_data).

Decomposition:
- Package imem_loader_pkg:
  - state enum {IDLE, COUNT, DATA, CHECK, DONE, ERROR}
  - MAGIC default
  - localparam BYTES_PER_WORD=4
- Sub-module word_packer:
  - 2-bit byte index, 32-bit shift/assemble register, byte XOR checksum
  - emits word_valid pulse plus word
  - clear input driven by the FSM on restart/reset
- Top module holds the FSM, word counter and output registers. It connects mem_we/mem_waddr/mem_wdata to a write port added to instruction_mem.

Test Plan:
- Reset held 2 cycles → cpu_hold=1, load_done=0, load_err=0, mem_we=0, s_ready=0 during reset and 1 after.
- Stream A5 02 13 00 00 00 B3 82 41 00 63 → mem_we pulses twice: addr0=0x00000013 and addr1=0x004182B3. Each pulse comes 1 cycle after the 4th byte. Afterwards words_loaded=2, load_done=1, cpu_hold=0.
- Same frame with checksum 0x64 → both writes still occur, then load_err=1, load_done=0, cpu_hold=1. A following good frame clears load_err and sets load_done.
- A5 00 and A5 41 (65>DEPTH) → ERROR immediately, no mem_we, load_err=1.
- Bytes 00 FF 13 before A5 are ignored. s_valid is dropped for 3 cycles between bytes 2 and 3 of a word → the word assembles correctly and exactly one write occurs.
- reset asserted after 6 data bytes of an N=2 frame → no write for word 1. A good frame afterwards writes from addr0. Sending A5 after DONE re-raises cpu_hold=1 and clears load_done.
